// File: rtl/gf2_mul32_seq_if.sv
// Operand/result handshake bundle for the sequential 32-bit carry-less multiplier.
// The master side drives operands and out_ready; the slave side is the multiplier.
interface gf2_mul32_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [62:0] y;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/gf2_mul32_seq.sv
// 32x32 carry-less multiplier built from one shared 16x16 core over three Karatsuba
// passes (low, middle, high). The recombination is folded into the HI-state update of y.
module gf2_mul32_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gf2_mul32_seq_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        MID  = 3'd2,
        HI   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [30:0] clmul16(input logic [15:0] x, input logic [15:0] w);
        logic [30:0] acc;
        acc = 31'd0;
        for (int i = 0; i < 16; i++) begin
            if (w[i]) begin
                acc = acc ^ ({15'd0, x} << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [30:0]      z0_q, z0_d;
    logic [30:0]      z1_q, z1_d;
    logic [62:0]      y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [15:0]      core_a_s;
    logic [15:0]      core_b_s;
    logic [30:0]      core_p_s;
    logic [30:0]      mid_s;

    // Core operand selection: the single multiplier is time-shared by state.
    always_comb begin
        core_a_s = 16'd0;
        core_b_s = 16'd0;
        case (state_q)
            LO: begin
                core_a_s = a_q[15:0];
                core_b_s = b_q[15:0];
            end
            MID: begin
                core_a_s = a_q[15:0] ^ a_q[31:16];
                core_b_s = b_q[15:0] ^ b_q[31:16];
            end
            HI: begin
                core_a_s = a_q[31:16];
                core_b_s = b_q[31:16];
            end
            default: begin
                core_a_s = 16'd0;
                core_b_s = 16'd0;
            end
        endcase
    end

    assign core_p_s = clmul16(core_a_s, core_b_s);
    // In HI, core_p_s is z2, so this is the Karatsuba middle term z0^z1^z2.
    assign mid_s    = z0_q ^ z1_q ^ core_p_s;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z0_d    = z0_q;
        z1_d    = z1_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = LO;
                end else begin
                    state_d = IDLE;
                end
            end
            LO: begin
                z0_d    = core_p_s;
                state_d = MID;
            end
            MID: begin
                z1_d    = core_p_s;
                state_d = HI;
            end
            HI: begin
                y_d     = {32'd0, z0_q} ^ ({32'd0, mid_s} << 16) ^ ({32'd0, core_p_s} << 32);
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (bus.in_valid) begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        state_d = LO;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            z0_q    <= 31'd0;
            z1_q    <= 31'd0;
            y_q     <= 63'd0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z0_q    <= z0_d;
            z1_q    <= z1_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.y         = y_q;
    assign busy          = (state_q != IDLE);
    assign done_cnt      = cnt_q;

endmodule
